acc_main_fsm: RTL and testbench
===============================

Name: acc_main_fsm

Overview:
Top-level sequencer of the RepVGG accelerator, directly downstream of the ICB config slave. It consumes the START pulse and the config registers (IN_ADDR, W3_ADDR, W1_ADDR, OUT_ADDR, MAPSIZE, ICH, OCH). It tiles the layer into output-channel × input-channel tiles and issues load/compute/writeback commands to the DMA engine and PE array. It returns a 1-cycle acc_done to the slave, which sets DONE.

Parameters:
ICH_TILE, 8, input channels per tile; power of two.
OCH_TILE, 8, output channels per tile; power of two.
AW, 32, address/length width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  START[0] from config slave; 1-cycle pulse
in_addr  in  AW  input feature map base
w3_addr  in  AW  3x3 weight base
w1_addr  in  AW  1x1 weight base
out_addr  in  AW  output feature map base
mapsize  in  16  feature map side length (MAPSIZE[15:0])
ich  in  16  input channels
och  in  16  output channels
dma_req  out  1  DMA command valid; held until dma_ack
dma_wr  out  1  0 = memory→buffer, 1 = buffer→memory
dma_sel  out  2  buffer: 0 IN, 1 W3, 2 W1, 3 OUT
dma_addr  out  AW  byte address
dma_len  out  AW  byte count
dma_ack  in  1  1-cycle transfer-complete pulse
pe_start  out  1  1-cycle compute pulse
pe_first  out  1  clear accumulators; valid with pe_start
pe_last  out  1  final ic tile; valid with pe_start
pe_done  in  1  1-cycle compute-complete pulse
busy  out  1  high in every state except IDLE
acc_done  out  1  1-cycle completion pulse to config slave

Behaviour:
- Reset: state IDLE. All outputs 0; all counters and pointers 0.
- States: IDLE → CFG → LD_IN → LD_W3 → LD_W1 → COMP → (LD_IN | WR_OUT) → … → FIN → IDLE.
- IDLE: on start=1, latch all config inputs and go to CFG. start is ignored in every other state.
- CFG (1 cycle) computes:
  - pix = mapsize*mapsize (32b)
  - n_ic = ich >> log2(ICH_TILE); n_oc = och >> log2(OCH_TILE); remainder channels are dropped.
  - in_len = pix*ICH_TILE
  - w3_len = 9*ICH_TILE*OCH_TILE
  - w1_len = ICH_TILE*OCH_TILE
  - out_len = pix*OCH_TILE
  - Pointers: in_p = in_addr, w3_p = w3_addr, w1_p = w1_addr, out_p = out_addr; ic_cnt = oc_cnt = 0.
  - If pix == 0, n_ic == 0 or n_oc == 0, go directly to FIN.
- LD_* / WR_OUT:
  - dma_req asserts the cycle after entry, with addr/len/sel/wr stable and unchanged until dma_ack.
  - On dma_ack: deassert dma_req the same edge and advance the pointer by its length (in_p += in_len, w3_p += w3_len, w1_p += w1_len, out_p += out_len).
  - dma_ack while dma_req = 0 is ignored.
- COMP:
  - pe_start pulses 1 cycle on entry, with pe_first = (ic_cnt == 0) and pe_last = (ic_cnt == n_ic-1).
  - Wait for pe_done.
  - On pe_done: if ic_cnt < n_ic-1, ic_cnt++ and go to LD_IN; else go to WR_OUT.
- After WR_OUT ack:
  - ic_cnt = 0 and in_p = in_addr (latched).
  - If oc_cnt < n_oc-1, oc_cnt++ and go to LD_IN; else go to FIN.
- Weights are stored oc-tile-major, ic-tile-minor, so w3_p and w1_p only ever advance.
- FIN: acc_done = 1 for exactly 1 cycle, then IDLE. busy drops the cycle after FIN.
- Arithmetic is modulo 2^AW; address wrap is not flagged.
- Async reset mid-operation returns the block to IDLE immediately. Outstanding DMA/PE pulses arriving afterwards are ignored.
- pe_done or dma_ack arriving in a state not waiting for it is ignored.

Decomposition:
- Shared package acc_pkg holds:
  - the state enum
  - DMA_SEL_IN/W3/W1/OUT constants
  - ICH_TILE/OCH_TILE defaults
- Sub-module acc_tile_cnt (n_ic / n_oc nested loop counters with first/last flags) is natural; everything else stays in one module.

Test Plan:
1. mapsize=4, ich=16, och=8; bases 0x1000/0x2000/0x3000/0x4000 → expect this DMA/PE order, then 1 acc_done:
   - (IN,0x1000,128), (W3,0x2000,576), (W1,0x3000,64)
   - COMP first=1 last=0
   - (IN,0x1080,128), (W3,0x2240,576), (W1,0x3040,64)
   - COMP first=0 last=1
   - (OUT wr,0x4000,128)
2. mapsize=2, ich=8, och=16 → two oc passes.
   - Second pass IN returns to in_addr.
   - W3 at w3_addr+576; OUT at out_addr+32.
   - pe_first=pe_last=1 on both COMPs.
3. och=4 (< OCH_TILE) → FIN directly; acc_done 2 cycles after start; no dma_req.
4. Second start pulse during LD_W3, and spurious dma_ack/pe_done in wrong states → no effect; sequence identical to scenario 1.
5. dma_ack delayed 20 cycles → dma_req/addr/len held constant for all 20 cycles.
6. rst_n low during COMP → all outputs 0 immediately; a new start after reset runs a full clean sequence.

Source files
------------

// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared types and constants for the RepVGG accelerator main sequencer.
//   acc_state_e   : sequencer state encoding
//   DMA_SEL_*     : DMA buffer selector codes carried on dma_sel
//   *_DEF         : default tile geometry and address width
//   is_dma_state  : true for the states that own an outstanding DMA command
// -----------------------------------------------------------------------------
package acc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_LD_IN,
    ST_LD_W3,
    ST_LD_W1,
    ST_COMP,
    ST_WR_OUT,
    ST_FIN
  } acc_state_e;

  localparam logic [1:0] DMA_SEL_IN  = 2'd0;
  localparam logic [1:0] DMA_SEL_W3  = 2'd1;
  localparam logic [1:0] DMA_SEL_W1  = 2'd2;
  localparam logic [1:0] DMA_SEL_OUT = 2'd3;

  localparam int ICH_TILE_DEF = 8;
  localparam int OCH_TILE_DEF = 8;
  localparam int AW_DEF       = 32;

  function automatic logic is_dma_state(input acc_state_e s);
    return (s == ST_LD_IN) || (s == ST_LD_W3) || (s == ST_LD_W1) || (s == ST_WR_OUT);
  endfunction

endpackage

// File: rtl/acc_tile_cnt.sv
// -----------------------------------------------------------------------------
// acc_tile_cnt
// Nested tile loop counters: input-channel tiles (inner) inside output-channel
// tiles (outer), with first/last flags for the sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero both counters (start of a layer)
//   ic_inc     : advance the inner counter
//   ic_clr     : zero the inner counter (end of an output tile)
//   oc_inc     : advance the outer counter
//   n_ic, n_oc : loop trip counts (>= 1 whenever the loops are in use)
//   ic_first   : inner counter is at its first tile
//   ic_last    : inner counter is at its last tile
//   oc_last    : outer counter is at its last tile
// -----------------------------------------------------------------------------
module acc_tile_cnt #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          ic_inc,
  input  logic          ic_clr,
  input  logic          oc_inc,
  input  logic [CW-1:0] n_ic,
  input  logic [CW-1:0] n_oc,
  output logic          ic_first,
  output logic          ic_last,
  output logic          oc_last
);

  logic [CW-1:0] ic_cnt;
  logic [CW-1:0] oc_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_cnt <= '0;
      oc_cnt <= '0;
    end else if (clr) begin
      ic_cnt <= '0;
      oc_cnt <= '0;
    end else begin
      if (ic_clr)      ic_cnt <= '0;
      else if (ic_inc) ic_cnt <= ic_cnt + CW'(1);
      if (oc_inc)      oc_cnt <= oc_cnt + CW'(1);
    end
  end

  assign ic_first = (ic_cnt == '0);
  assign ic_last  = (ic_cnt == n_ic - CW'(1));
  assign oc_last  = (oc_cnt == n_oc - CW'(1));

endmodule

// File: rtl/acc_main_fsm.sv
// -----------------------------------------------------------------------------
// acc_main_fsm
// Top-level sequencer of the RepVGG accelerator. On start it latches the layer
// configuration, tiles the layer into (output-channel x input-channel) tiles
// and, per tile, loads IN / W3 / W1 through the DMA engine, runs the PE array,
// and after the last input tile of an output tile writes OUT back. A 1-cycle
// acc_done pulse tells the config slave the layer is finished.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : 1-cycle start pulse (honoured only in IDLE)
//   in/w3/w1/out_addr   : base addresses
//   mapsize, ich, och   : feature map side, input / output channel counts
//   dma_req .. dma_len  : DMA command, held stable until dma_ack
//   dma_ack             : 1-cycle transfer-complete pulse
//   pe_start/first/last : 1-cycle compute command with accumulator flags
//   pe_done             : 1-cycle compute-complete pulse
//   busy                : high in every state except IDLE
//   acc_done            : 1-cycle completion pulse
// -----------------------------------------------------------------------------
module acc_main_fsm
  import acc_pkg::*;
#(
  parameter int ICH_TILE = ICH_TILE_DEF,
  parameter int OCH_TILE = OCH_TILE_DEF,
  parameter int AW       = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] in_addr,
  input  logic [AW-1:0] w3_addr,
  input  logic [AW-1:0] w1_addr,
  input  logic [AW-1:0] out_addr,
  input  logic [15:0]   mapsize,
  input  logic [15:0]   ich,
  input  logic [15:0]   och,
  output logic          dma_req,
  output logic          dma_wr,
  output logic [1:0]    dma_sel,
  output logic [AW-1:0] dma_addr,
  output logic [AW-1:0] dma_len,
  input  logic          dma_ack,
  output logic          pe_start,
  output logic          pe_first,
  output logic          pe_last,
  input  logic          pe_done,
  output logic          busy,
  output logic          acc_done
);

  localparam int ICH_SH = $clog2(ICH_TILE);
  localparam int OCH_SH = $clog2(OCH_TILE);
  localparam logic [AW-1:0] W3_LEN = AW'(9 * ICH_TILE * OCH_TILE);
  localparam logic [AW-1:0] W1_LEN = AW'(ICH_TILE * OCH_TILE);

  acc_state_e state_q, state_d;

  // Latched configuration
  logic [AW-1:0] in_base_q, w3_base_q, w1_base_q, out_base_q;
  logic [15:0]   mapsize_q, ich_q, och_q;

  // Running DMA pointers
  logic [AW-1:0] in_p, w3_p, w1_p, out_p;

  logic          dma_req_q;
  logic          pe_start_q, pe_first_q, pe_last_q;

  // Derived layer geometry; constant once the configuration is latched.
  logic [AW-1:0] pix, in_len, out_len;
  logic [15:0]   n_ic, n_oc;
  logic          cfg_empty;

  logic dma_fire, pe_fire, wr_fire, comp_entry;
  logic ic_first, ic_last, oc_last;

  assign pix       = AW'(mapsize_q) * AW'(mapsize_q);
  assign in_len    = pix * AW'(ICH_TILE);
  assign out_len   = pix * AW'(OCH_TILE);
  assign n_ic      = ich_q >> ICH_SH;
  assign n_oc      = och_q >> OCH_SH;
  assign cfg_empty = (pix == '0) || (n_ic == '0) || (n_oc == '0);

  // An ack only counts while a command is actually outstanding.
  assign dma_fire   = dma_req_q & dma_ack;
  assign pe_fire    = (state_q == ST_COMP) & pe_done;
  assign wr_fire    = dma_fire & (state_q == ST_WR_OUT);
  assign comp_entry = (state_d == ST_COMP) & (state_q != ST_COMP);

  acc_tile_cnt #(.CW(16)) u_tile_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == ST_CFG),
    .ic_inc   (pe_fire & ~ic_last),
    .ic_clr   (wr_fire),
    .oc_inc   (wr_fire & ~oc_last),
    .n_ic     (n_ic),
    .n_oc     (n_oc),
    .ic_first (ic_first),
    .ic_last  (ic_last),
    .oc_last  (oc_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CFG;
      ST_CFG:    state_d = cfg_empty ? ST_FIN : ST_LD_IN;
      ST_LD_IN:  if (dma_fire) state_d = ST_LD_W3;
      ST_LD_W3:  if (dma_fire) state_d = ST_LD_W1;
      ST_LD_W1:  if (dma_fire) state_d = ST_COMP;
      ST_COMP:   if (pe_fire) state_d = ic_last ? ST_WR_OUT : ST_LD_IN;
      ST_WR_OUT: if (dma_fire) state_d = oc_last ? ST_FIN : ST_LD_IN;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_base_q  <= '0;
      w3_base_q  <= '0;
      w1_base_q  <= '0;
      out_base_q <= '0;
      mapsize_q  <= '0;
      ich_q      <= '0;
      och_q      <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      in_base_q  <= in_addr;
      w3_base_q  <= w3_addr;
      w1_base_q  <= w1_addr;
      out_base_q <= out_addr;
      mapsize_q  <= mapsize;
      ich_q      <= ich;
      och_q      <= och;
    end
  end

  // Weights are stored oc-tile-major / ic-tile-minor, so w3_p and w1_p only
  // ever advance; the input pointer rewinds at the start of each output tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_p  <= '0;
      w3_p  <= '0;
      w1_p  <= '0;
      out_p <= '0;
    end else if (state_q == ST_CFG) begin
      in_p  <= in_base_q;
      w3_p  <= w3_base_q;
      w1_p  <= w1_base_q;
      out_p <= out_base_q;
    end else if (dma_fire) begin
      case (state_q)
        ST_LD_IN: in_p <= in_p + in_len;
        ST_LD_W3: w3_p <= w3_p + W3_LEN;
        ST_LD_W1: w1_p <= w1_p + W1_LEN;
        ST_WR_OUT: begin
          out_p <= out_p + out_len;
          in_p  <= in_base_q;
        end
        default: ;
      endcase
    end
  end

  // dma_req rises the cycle after a DMA state is entered and drops on the
  // accepting edge, which is also the edge that leaves the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_req_q  <= 1'b0;
      pe_start_q <= 1'b0;
      pe_first_q <= 1'b0;
      pe_last_q  <= 1'b0;
    end else begin
      dma_req_q  <= is_dma_state(state_q) & ~dma_fire;
      pe_start_q <= comp_entry;
      pe_first_q <= comp_entry & ic_first;
      pe_last_q  <= comp_entry & ic_last;
    end
  end

  always_comb begin
    dma_sel  = '0;
    dma_wr   = 1'b0;
    dma_addr = '0;
    dma_len  = '0;
    if (dma_req_q) begin
      case (state_q)
        ST_LD_IN: begin
          dma_sel  = DMA_SEL_IN;
          dma_addr = in_p;
          dma_len  = in_len;
        end
        ST_LD_W3: begin
          dma_sel  = DMA_SEL_W3;
          dma_addr = w3_p;
          dma_len  = W3_LEN;
        end
        ST_LD_W1: begin
          dma_sel  = DMA_SEL_W1;
          dma_addr = w1_p;
          dma_len  = W1_LEN;
        end
        ST_WR_OUT: begin
          dma_sel  = DMA_SEL_OUT;
          dma_wr   = 1'b1;
          dma_addr = out_p;
          dma_len  = out_len;
        end
        default: ;
      endcase
    end
  end

  assign dma_req  = dma_req_q;
  assign pe_start = pe_start_q;
  assign pe_first = pe_first_q;
  assign pe_last  = pe_last_q;
  assign busy     = (state_q != ST_IDLE);
  assign acc_done = (state_q == ST_FIN);

endmodule

// File: tb/tb_acc_main_fsm.sv
// -----------------------------------------------------------------------------
// tb_acc_main_fsm
// Self-checking bench for acc_main_fsm. A responder plays DMA engine and PE
// array, logs every command the sequencer issues, and the log is compared
// against a reference list built from the layer geometry with plain
// arithmetic (tile index times transfer length from the base address).
// -----------------------------------------------------------------------------
module tb_acc_main_fsm;

  localparam int AW         = 32;
  localparam int JOB_BUDGET = 4000;

  typedef struct {
    logic [15:0] mapsize;
    logic [15:0] ich;
    logic [15:0] och;
    logic [31:0] in_a;
    logic [31:0] w3_a;
    logic [31:0] w1_a;
    logic [31:0] out_a;
  } cfg_t;

  typedef struct {
    cfg_t c;
    int   dly;       // ack / done latency in cycles, -1 = random 0..4
    bit   spur;      // inject stray acks, done pulses and start pulses
    bit   restart;   // extra start pulse during the first W3 load
    bit   hand;      // also compare against the hand-written scenario-1 list
    int   exp_dma;
    int   exp_pe;
    int   exp_done;  // cycles from start to acc_done, -1 = not checked
  } vec_t;

  typedef struct packed {
    logic        is_pe;
    logic [1:0]  sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] len;
    logic        first;
    logic        last;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] in_addr, w3_addr, w1_addr, out_addr;
  logic [15:0]   mapsize, ich, och;
  logic          dma_req, dma_wr;
  logic [1:0]    dma_sel;
  logic [AW-1:0] dma_addr, dma_len;
  logic          dma_ack;
  logic          pe_start, pe_first, pe_last;
  logic          pe_done;
  logic          busy, acc_done;

  acc_main_fsm #(.ICH_TILE(8), .OCH_TILE(8), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_addr  (in_addr),
    .w3_addr  (w3_addr),
    .w1_addr  (w1_addr),
    .out_addr (out_addr),
    .mapsize  (mapsize),
    .ich      (ich),
    .och      (och),
    .dma_req  (dma_req),
    .dma_wr   (dma_wr),
    .dma_sel  (dma_sel),
    .dma_addr (dma_addr),
    .dma_len  (dma_len),
    .dma_ack  (dma_ack),
    .pe_start (pe_start),
    .pe_first (pe_first),
    .pe_last  (pe_last),
    .pe_done  (pe_done),
    .busy     (busy),
    .acc_done (acc_done)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;

  ev_t  obs_q[$];
  ev_t  exp_q[$];
  int   done_cyc;
  int   n_done;
  int   hold_err;
  bit   tmo;
  logic [1:0] post_flags;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] outs_now();
    return 96'({dma_req, dma_wr, dma_sel, dma_addr, dma_len,
                pe_start, pe_first, pe_last, busy, acc_done});
  endfunction

  function automatic ev_t mk_dma(input logic [1:0] sel, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] len);
    return '{is_pe: 1'b0, sel: sel, wr: wr, addr: addr, len: len, first: 1'b0, last: 1'b0};
  endfunction

  function automatic ev_t mk_pe(input logic first, input logic last);
    return '{is_pe: 1'b1, sel: 2'd0, wr: 1'b0, addr: 32'd0, len: 32'd0, first: first, last: last};
  endfunction

  // Reference: command order for a layer, every address computed directly
  // from its tile index rather than accumulated step by step.
  function automatic void build_model(input cfg_t c);
    logic [31:0] pix, in_len, out_len;
    int n_ic, n_oc, k;
    exp_q.delete();
    pix     = 32'(c.mapsize) * 32'(c.mapsize);
    in_len  = pix * 32'd8;
    out_len = pix * 32'd8;
    n_ic    = int'(c.ich) / 8;
    n_oc    = int'(c.och) / 8;
    if (pix == 0 || n_ic == 0 || n_oc == 0) return;
    for (int oc = 0; oc < n_oc; oc++) begin
      for (int ic = 0; ic < n_ic; ic++) begin
        k = oc * n_ic + ic;
        exp_q.push_back(mk_dma(2'd0, 1'b0, c.in_a + 32'(ic) * in_len, in_len));
        exp_q.push_back(mk_dma(2'd1, 1'b0, c.w3_a + 32'(k) * 32'd576, 32'd576));
        exp_q.push_back(mk_dma(2'd2, 1'b0, c.w1_a + 32'(k) * 32'd64, 32'd64));
        exp_q.push_back(mk_pe(ic == 0, ic == n_ic - 1));
      end
      exp_q.push_back(mk_dma(2'd3, 1'b1, c.out_a + 32'(oc) * out_len, out_len));
    end
  endfunction

  function automatic void load_hand_scn1();
    exp_q.delete();
    exp_q.push_back(mk_dma(2'd0, 1'b0, 32'h1000, 32'd128));
    exp_q.push_back(mk_dma(2'd1, 1'b0, 32'h2000, 32'd576));
    exp_q.push_back(mk_dma(2'd2, 1'b0, 32'h3000, 32'd64));
    exp_q.push_back(mk_pe(1'b1, 1'b0));
    exp_q.push_back(mk_dma(2'd0, 1'b0, 32'h1080, 32'd128));
    exp_q.push_back(mk_dma(2'd1, 1'b0, 32'h2240, 32'd576));
    exp_q.push_back(mk_dma(2'd2, 1'b0, 32'h3040, 32'd64));
    exp_q.push_back(mk_pe(1'b0, 1'b1));
    exp_q.push_back(mk_dma(2'd3, 1'b1, 32'h4000, 32'd128));
  endfunction

  task automatic compare_events(input string name);
    int n;
    check({name, "_ev_count"}, 96'(obs_q.size()), 96'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_ev%0d", name, i), 96'(obs_q[i]), 96'(exp_q[i]));
  endtask

  // Drives one layer and plays DMA engine / PE array until acc_done.
  task automatic run_job(input cfg_t c, input int dly, input bit spur,
                         input bit restart, input bit abort_pe);
    ev_t cur;
    int  wait_d, pe_wait;
    bit  pend_dma, pend_pe, ack_prev, restarted;
    obs_q.delete();
    done_cyc = -1; n_done = 0; hold_err = 0; tmo = 1'b1; post_flags = 2'b11;
    cur = '0; wait_d = 0; pe_wait = 0;
    pend_dma = 0; pend_pe = 0; ack_prev = 0; restarted = 0;
    @(negedge clk);
    in_addr = c.in_a; w3_addr = c.w3_a; w1_addr = c.w1_a; out_addr = c.out_a;
    mapsize = c.mapsize; ich = c.ich; och = c.och;
    start = 1'b1;
    for (int cyc = 1; cyc <= JOB_BUDGET; cyc++) begin
      @(negedge clk);
      start = 1'b0; dma_ack = 1'b0; pe_done = 1'b0;
      if (ack_prev && dma_req) hold_err++;
      ack_prev = 0;
      if (dma_req) begin
        if (!pend_dma) begin
          pend_dma = 1;
          cur = mk_dma(dma_sel, dma_wr, dma_addr, dma_len);
          obs_q.push_back(cur);
          wait_d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
          if (restart && !restarted && dma_sel == 2'd1) begin
            start = 1'b1;
            restarted = 1;
          end
        end else if ({dma_sel, dma_wr, dma_addr, dma_len} != {cur.sel, cur.wr, cur.addr, cur.len}) begin
          hold_err++;
        end
        if (wait_d == 0) begin
          dma_ack = 1'b1; pend_dma = 0; ack_prev = 1;
        end else begin
          wait_d--;
        end
      end else if (spur && $urandom_range(0, 2) == 0) begin
        dma_ack = 1'b1;
      end
      if (pe_start) begin
        obs_q.push_back(mk_pe(pe_first, pe_last));
        pend_pe = 1;
        pe_wait = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
        if (abort_pe) begin
          tmo = 1'b0;
          return;
        end
      end
      if (pend_pe) begin
        if (pe_wait == 0) begin
          pe_done = 1'b1; pend_pe = 0;
        end else begin
          pe_wait--;
        end
      end else if (spur && $urandom_range(0, 2) == 0) begin
        pe_done = 1'b1;
      end
      if (spur && busy && !acc_done && $urandom_range(0, 4) == 0) start = 1'b1;
      if (acc_done) begin
        n_done++;
        done_cyc = cyc;
        tmo = 1'b0;
        break;
      end
    end
    if (!tmo) begin
      @(negedge clk);
      start = 1'b0; dma_ack = 1'b0; pe_done = 1'b0;
      post_flags = {busy, acc_done};
    end
    start = 1'b0; dma_ack = 1'b0; pe_done = 1'b0;
  endtask

  task automatic job_checks(input string name, input cfg_t c);
    check({name, "_timeout"}, 96'(tmo), 96'(0));
    check({name, "_done_pulses"}, 96'(n_done), 96'(1));
    check({name, "_idle_after_fin"}, 96'(post_flags), 96'(0));
    check({name, "_dma_hold"}, 96'(hold_err), 96'(0));
    build_model(c);
    compare_events(name);
    if (tmo) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  function automatic vec_t mk_vec(input logic [15:0] m, i, o,
                                  input logic [31:0] ia, wa3, wa1, oa,
                                  input int dly, input bit spur, restart, hand,
                                  input int e_dma, e_pe, e_done);
    vec_t v;
    v.c = '{mapsize: m, ich: i, och: o, in_a: ia, w3_a: wa3, w1_a: wa1, out_a: oa};
    v.dly = dly; v.spur = spur; v.restart = restart; v.hand = hand;
    v.exp_dma = e_dma; v.exp_pe = e_pe; v.exp_done = e_done;
    return v;
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    cfg_t c1, rc;
    int   n_dma, n_pe;

    vecs[0] = mk_vec(16'd4, 16'd16, 16'd8,  32'h1000, 32'h2000, 32'h3000, 32'h4000, 1,  0, 0, 1, 7, 2, -1);
    vecs[1] = mk_vec(16'd2, 16'd8,  16'd16, 32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h4_0000, 0, 0, 0, 0, 8, 2, -1);
    vecs[2] = mk_vec(16'd4, 16'd16, 16'd4,  32'h1000, 32'h2000, 32'h3000, 32'h4000, 1,  0, 0, 0, 0, 0, 2);
    vecs[3] = mk_vec(16'd4, 16'd16, 16'd8,  32'h1000, 32'h2000, 32'h3000, 32'h4000, 1,  1, 1, 1, 7, 2, -1);
    vecs[4] = mk_vec(16'd4, 16'd16, 16'd8,  32'h1000, 32'h2000, 32'h3000, 32'h4000, 20, 0, 0, 1, 7, 2, -1);
    vecs[5] = mk_vec(16'd0, 16'd16, 16'd16, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 1,  0, 0, 0, 0, 0, 2);
    vecs[6] = mk_vec(16'd3, 16'd7,  16'd16, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 1,  0, 0, 0, 0, 0, 2);
    c1 = vecs[0].c;

    rst_n = 1'b0; start = 1'b0; dma_ack = 1'b0; pe_done = 1'b0;
    in_addr = '0; w3_addr = '0; w1_addr = '0; out_addr = '0;
    mapsize = '0; ich = '0; och = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_now(), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", outs_now(), 96'(0));

    // Table-driven scenarios
    for (int v = 0; v < 7; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      run_job(vecs[v].c, vecs[v].dly, vecs[v].spur, vecs[v].restart, 1'b0);
      n_dma = 0; n_pe = 0;
      foreach (obs_q[i]) begin
        if (obs_q[i].is_pe) n_pe++;
        else                n_dma++;
      end
      check({nm, "_dma_count"}, 96'(n_dma), 96'(vecs[v].exp_dma));
      check({nm, "_pe_count"},  96'(n_pe),  96'(vecs[v].exp_pe));
      if (vecs[v].exp_done >= 0)
        check({nm, "_done_latency"}, 96'(done_cyc), 96'(vecs[v].exp_done));
      if (vecs[v].hand) begin
        load_hand_scn1();
        compare_events({nm, "_hand"});
      end
      job_checks(nm, vecs[v].c);
    end

    // Reset while the PE array is computing, with stray pulses around it
    run_job(c1, 2, 1'b0, 1'b0, 1'b1);
    check("abort_reached_comp", 96'(obs_q.size()), 96'(4));
    #2 rst_n = 1'b0;
    #1 check("outputs_during_reset", outs_now(), 96'(0));
    pe_done = 1'b1; dma_ack = 1'b1;
    @(negedge clk);
    pe_done = 1'b0; dma_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    pe_done = 1'b1; dma_ack = 1'b1;
    @(negedge clk);
    pe_done = 1'b0; dma_ack = 1'b0;
    @(negedge clk);
    check("idle_after_mid_reset", outs_now(), 96'(0));
    run_job(c1, 1, 1'b0, 1'b0, 1'b0);
    load_hand_scn1();
    compare_events("rerun_hand");
    job_checks("rerun", c1);

    // Randomized layers against the reference model
    for (int r = 0; r < 20; r++) begin
      rc.mapsize = 16'($urandom_range(0, 6));
      rc.ich     = 16'($urandom_range(0, 40));
      rc.och     = 16'($urandom_range(0, 40));
      rc.in_a    = $urandom;
      rc.w3_a    = $urandom;
      rc.w1_a    = $urandom;
      rc.out_a   = (r % 4 == 0) ? 32'hFFFF_FFC0 : $urandom;
      run_job(rc, -1, (r % 2) == 1, 1'b0, 1'b0);
      job_checks($sformatf("rnd%0d", r), rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
